// File: rtl/icache_ctrl_pkg.sv
// Shared encodings, field widths and helpers for the direct-mapped instruction cache.
package icache_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_e;

  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 3;
  localparam int BLOCK_W  = 128;
  localparam int WORD_W   = 32;

  // Byte 0 of the block sits in bits [7:0], so word k is simply bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                 input logic [OFFSET_W-1:0] off);
    return blk[WORD_W*int'(off) +: WORD_W];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache: one write port, combinational read,
// asynchronous clear of the valid bits only.
module icache_line_store
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS = 1 << INDEX_W,
  parameter int LINE_W     = BLOCK_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [LINE_W-1:0]   wr_data_i,
  input  logic [INDEX_W-1:0]  rd_index_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [LINE_W-1:0]   rd_data_o
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller: hit detection, miss FSM and fill.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT/MISS_COUNT outputs.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS  = 1 << INDEX_W,
  parameter int BLOCK_BYTES = 4 << OFFSET_W,
  parameter int ADDR_WIDTH  = TAG_W + INDEX_W + OFFSET_W + 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              PC,
  output logic [WORD_W-1:0]        INSTRUCTION,
  output logic                     BUSYWAIT,
  output logic [TAG_W+INDEX_W-1:0] MEM_ADDRESS,
  output logic                     MEM_READ,
  input  logic [BLOCK_W-1:0]       MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]              HIT_COUNT,
  output logic [15:0]              MISS_COUNT
`endif
);

  localparam int LINE_W = BLOCK_BYTES * 8;

  state_e                   state_q;
  logic                     mem_read_q;
  logic [TAG_W+INDEX_W-1:0] mem_addr_q;
  logic [LINE_W-1:0]        fill_data_q;

  logic [OFFSET_W-1:0] pc_offset;
  logic [INDEX_W-1:0]  pc_index;
  logic [TAG_W-1:0]    pc_tag;
  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [LINE_W-1:0]   line_data;
  logic                hit;
  logic                line_we;
  logic                unused_pc;

  assign pc_offset = PC[OFFSET_W+1:2];
  assign pc_index  = PC[OFFSET_W+INDEX_W+1:OFFSET_W+2];
  assign pc_tag    = PC[ADDR_WIDTH-1:ADDR_WIDTH-TAG_W];
  assign unused_pc = ^{PC[31:ADDR_WIDTH], PC[1:0]};

  // Writes always target the latched miss address, never the live PC.
  assign line_we = (state_q == S_UPDATE);

  icache_line_store #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .LINE_W     (LINE_W)
  ) u_store (
    .clk        (CLK),
    .rst_n      (RESET),
    .we_i       (line_we),
    .wr_index_i (mem_addr_q[INDEX_W-1:0]),
    .wr_tag_i   (mem_addr_q[TAG_W+INDEX_W-1:INDEX_W]),
    .wr_data_i  (fill_data_q),
    .rd_index_i (pc_index),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data)
  );

  assign hit         = line_valid && (line_tag == pc_tag);
  assign INSTRUCTION = line_valid ? word_sel(line_data, pc_offset) : '0;

  // A miss stalls the CPU in the very cycle it is seen; reset forces the stall low.
  assign BUSYWAIT    = RESET && ((state_q != S_IDLE) || !hit);
  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = mem_addr_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!hit) begin
            mem_addr_q <= {pc_tag, pc_index};
            mem_read_q <= 1'b1;
            state_q    <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            mem_read_q <= 1'b0;
            state_q    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          state_q <= S_IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // Memory data is only valid in the cycle MEM_BUSYWAIT falls.
  always_ff @(posedge CLK) begin
    if ((state_q == S_MEM_READ) && !MEM_BUSYWAIT) begin
      fill_data_q <= MEM_READDATA;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0]           hit_cnt_q;
  logic [15:0]           miss_cnt_q;
  logic [ADDR_WIDTH-1:0] pc_prev_q;

  // A PC held across several cycles is a single fetch and counts once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      pc_prev_q  <= '0;
    end else begin
      pc_prev_q <= PC[ADDR_WIDTH-1:0];
      if ((state_q == S_IDLE) && !hit) begin
        miss_cnt_q <= sat_inc16(miss_cnt_q);
      end
      if ((state_q == S_IDLE) && hit && (PC[ADDR_WIDTH-1:0] != pc_prev_q)) begin
        hit_cnt_q <= sat_inc16(hit_cnt_q);
      end
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule
